goofy_ram_arbiter: RTL and testbench

- Shares the single-port 8-bit RAM between two requesters: port 0 (core fetch/data) and port 1 (loader/debug/DMA).
- Per-port req/gnt/rvalid handshake, round-robin arbitration, registered RAM drive, and read-data return after a fixed RAM latency.
- Sits between the requesters and the RAM instance; it is the only driver of the RAM save, data-in and address pins.

---
 rtl/goofy_ram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_goofy_ram_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/goofy_ram_arbiter.sv
// goofy_ram_arbiter
// Shares one single-port RAM between two requesters (port 0: core, port 1:
// loader/debug/DMA). Round-robin arbitration, registered RAM drive and
// read-data return after a fixed RAM latency of RD_LAT cycles.
//
// Optional feature macro: GOOFY_ARB_LOCK_EN
//   When defined, adds lock0/lock1 inputs and the LOCK_MAX parameter. A
//   winner holding lock keeps priority on ties for up to LOCK_MAX
//   consecutive locked grants.
//
// Ports:
//   clk, res             clock, asynchronous active-high reset
//   req0/req1            access request, held until gnt
//   we0/we1              1 = write, 0 = read
//   addr0/addr1          access address
//   wdata0/wdata1        write data
//   lock0/lock1          (GOOFY_ARB_LOCK_EN only) priority lock request
//   gnt0/gnt1            one-cycle pulse, RAM driven this cycle
//   rvalid0/rvalid1      one-cycle pulse, rdata valid for that port
//   rdata                shared read data
//   busy                 high whenever the FSM is not IDLE
//   ram_save/ram_in/ram_addr  RAM write enable / write data / address
//   ram_out              RAM read data
module goofy_ram_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
`ifdef GOOFY_ARB_LOCK_EN
  ,
  parameter int LOCK_MAX = 8
`endif
) (
  input  logic          clk,
  input  logic          res,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
`ifdef GOOFY_ARB_LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          ram_save,
  output logic [DW-1:0] ram_in,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_out
);

  localparam int CW = 2;  // wait counter covers RD_LAT-1 for RD_LAT in 1..4

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RWAIT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic          we_q, we_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic          ram_save_q, ram_save_d;
  logic [DW-1:0] ram_in_q, ram_in_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;

  logic          any_req_s;
  logic          win_s;

  assign any_req_s = req0 | req1;

`ifdef GOOFY_ARB_LOCK_EN
  localparam int LCW = $clog2(LOCK_MAX + 1);

  logic           lock_act_q, lock_act_d;
  logic           lock_own_q, lock_own_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           lock_hold_s;
  logic           lock_expire_s;
  logic           win_lock_s;

  // Winner selection: a live lock beats round-robin on ties until it has
  // used up LOCK_MAX grants, then the other port gets the tie once.
  always_comb begin
    win_s         = req1;
    lock_expire_s = 1'b0;
    lock_hold_s   = lock_act_q & (lock_own_q ? (req1 & lock1) : (req0 & lock0));
    if (req0 && req1) begin
      if (lock_hold_s) begin
        if (lock_cnt_q >= LCW'(LOCK_MAX)) begin
          win_s         = ~lock_own_q;
          lock_expire_s = 1'b1;
        end else begin
          win_s = lock_own_q;
        end
      end else begin
        win_s = ~last_q;
      end
    end else begin
      win_s = req1;
    end
    win_lock_s = win_s ? lock1 : lock0;
  end

  // Lock bookkeeping, evaluated only on IDLE arbitration cycles.
  always_comb begin
    lock_act_d = lock_act_q;
    lock_own_d = lock_own_q;
    lock_cnt_d = lock_cnt_q;
    if (state_q == IDLE) begin
      if (!lock_hold_s || lock_expire_s) begin
        lock_act_d = 1'b0;
        lock_cnt_d = '0;
      end else begin
        lock_act_d = lock_act_q;
      end
      if (any_req_s && win_lock_s) begin
        if (lock_hold_s && !lock_expire_s && (win_s == lock_own_q)) begin
          if (lock_cnt_q < LCW'(LOCK_MAX)) begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
          end else begin
            lock_cnt_d = lock_cnt_q;
          end
        end else begin
          lock_act_d = 1'b1;
          lock_own_d = win_s;
          lock_cnt_d = LCW'(1);
        end
      end else begin
        lock_own_d = lock_own_q;
      end
    end else begin
      lock_act_d = lock_act_q;
    end
  end

  // Lock state registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      lock_act_q <= 1'b0;
      lock_own_q <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      lock_act_q <= lock_act_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  // Plain round-robin: on a tie the port that was not granted last wins.
  always_comb begin
    win_s = req1;
    if (req0 && req1) begin
      win_s = ~last_q;
    end else begin
      win_s = req1;
    end
  end
`endif

  // Next state and next registered outputs. Outputs are computed one cycle
  // ahead so that every pin toggles straight out of a flop.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    we_d       = we_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rdata_d    = rdata_q;
    busy_d     = 1'b0;
    ram_save_d = 1'b0;
    ram_in_d   = ram_in_q;
    ram_addr_d = ram_addr_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d = ACCESS;
          sel_d   = win_s;
          last_d  = win_s;
          busy_d  = 1'b1;
          if (win_s) begin
            gnt1_d     = 1'b1;
            we_d       = we1;
            ram_save_d = we1;
            ram_addr_d = addr1;
            ram_in_d   = wdata1;
          end else begin
            gnt0_d     = 1'b1;
            we_d       = we0;
            ram_save_d = we0;
            ram_addr_d = addr0;
            ram_in_d   = wdata0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = RWAIT;
          cnt_d   = CW'(RD_LAT - 1);
          busy_d  = 1'b1;
        end
      end
      RWAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          rdata_d = ram_out;
          if (sel_q) begin
            rvalid1_d = 1'b1;
          end else begin
            rvalid0_d = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q - CW'(1);
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      ram_save_q <= 1'b0;
      ram_in_q   <= '0;
      ram_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      ram_save_q <= ram_save_d;
      ram_in_q   <= ram_in_d;
      ram_addr_q <= ram_addr_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign ram_save = ram_save_q;
  assign ram_in   = ram_in_q;
  assign ram_addr = ram_addr_q;

endmodule

// File: tb/tb_goofy_ram_arbiter.sv
// Testbench for goofy_ram_arbiter: behavioural RAM with RD_LAT=1, a
// scoreboard of expected grants and read returns, and scenario tasks.
module tb_goofy_ram_arbiter;
  localparam int AW     = 16;
  localparam int DW     = 8;
  localparam int RD_LAT = 1;
`ifdef GOOFY_ARB_LOCK_EN
  localparam int LOCK_MAX = 2;
`endif

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } rd_t;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
`ifdef GOOFY_ARB_LOCK_EN
  logic          lock0 = 1'b0, lock1 = 1'b0;
`endif
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, ram_save;
  logic [DW-1:0] rdata, ram_in;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_out;

  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            gnt_q[$];
  rd_t           rd_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  goofy_ram_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT)
`ifdef GOOFY_ARB_LOCK_EN
    , .LOCK_MAX(LOCK_MAX)
`endif
  ) dut (
    .clk(clk), .res(res),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef GOOFY_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .ram_save(ram_save), .ram_in(ram_in),
    .ram_addr(ram_addr), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM, one cycle read latency.
  always @(posedge clk) begin
    if (ram_save) mem[ram_addr] <= ram_in;
    ram_out <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (port == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end
  endtask

  // Scoreboard side: pops expected grants / read returns as the DUT emits them.
  task automatic monitor();
    rd_t e;
    int  g;
    int  eg;
    forever begin
      @(negedge clk);
      if (!res) begin
        if (gnt0 || gnt1) begin
          n_cmp++;
          g = gnt1 ? 1 : 0;
          if (gnt0 && gnt1) begin
            n_err++; $display("FAIL sb_gnt_onehot: got gnt0=%b gnt1=%b, required at most one", gnt0, gnt1);
          end else if (gnt_q.size() == 0) begin
            n_err++; $display("FAIL sb_gnt_unexpected: got gnt on port %0d, required none", g);
          end else begin
            eg = gnt_q.pop_front();
            if (g !== eg) begin
              n_err++; $display("FAIL sb_gnt_order: got port %0d, required port %0d", g, eg);
            end
          end
        end
        if (rvalid0 || rvalid1) begin
          n_cmp++;
          g = rvalid1 ? 1 : 0;
          if (rvalid0 && rvalid1) begin
            n_err++; $display("FAIL sb_rvalid_onehot: got rvalid0=%b rvalid1=%b, required at most one", rvalid0, rvalid1);
          end else if (rd_q.size() == 0) begin
            n_err++; $display("FAIL sb_rvalid_unexpected: got rvalid on port %0d, required none", g);
          end else begin
            e = rd_q.pop_front();
            if (g !== e.port || rdata !== e.data) begin
              n_err++; $display("FAIL sb_read: got port %0d data %h, required port %0d data %h", g, rdata, e.port, e.data);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    step(); step();
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1, busy, ram_save} !== 6'b0 || ram_addr !== 16'h0000 || ram_in !== 8'h00 || rdata !== 8'h00) begin
      n_err++; $display("FAIL reset_state: got ctl=%b addr=%h in=%h rdata=%h, required all zero",
                        {gnt0, gnt1, rvalid0, rvalid1, busy, ram_save}, ram_addr, ram_in, rdata);
    end
    res = 1'b0;
    step();
  endtask

  task automatic test_write(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [1:0] eg;
    eg = (port == 0) ? 2'b01 : 2'b10;
    gnt_q.push_back(port);
    ref_mem[a] = d;
    drive(port, 1'b1, a, d);
    step();
    n_cmp++;
    if ({gnt1, gnt0} !== eg || ram_save !== 1'b1 || ram_addr !== a || ram_in !== d || busy !== 1'b1) begin
      n_err++; $display("FAIL write_access: got gnt=%b save=%b addr=%h in=%h busy=%b, required gnt=%b save=1 addr=%h in=%h busy=1",
                        {gnt1, gnt0}, ram_save, ram_addr, ram_in, busy, eg, a, d);
    end
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    step();
    n_cmp++;
    if ({gnt1, gnt0} !== 2'b00 || ram_save !== 1'b0 || busy !== 1'b0 || ram_addr !== a) begin
      n_err++; $display("FAIL write_after: got gnt=%b save=%b busy=%b addr=%h, required gnt=00 save=0 busy=0 addr=%h",
                        {gnt1, gnt0}, ram_save, busy, ram_addr, a);
    end
  endtask

  task automatic test_read(input int port, input logic [AW-1:0] a);
    logic [1:0] eg;
    eg = (port == 0) ? 2'b01 : 2'b10;
    gnt_q.push_back(port);
    rd_q.push_back('{port, ref_mem[a]});
    drive(port, 1'b0, a, 8'h00);
    step();
    n_cmp++;
    if ({gnt1, gnt0} !== eg || ram_save !== 1'b0 || ram_addr !== a) begin
      n_err++; $display("FAIL read_access: got gnt=%b save=%b addr=%h, required gnt=%b save=0 addr=%h", {gnt1, gnt0}, ram_save, ram_addr, eg, a);
    end
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b1 || {rvalid1, rvalid0} !== 2'b00 || ram_save !== 1'b0 || ram_addr !== a) begin
      n_err++; $display("FAIL read_wait: got busy=%b rvalid=%b save=%b addr=%h, required busy=1 rvalid=00 save=0 addr=%h",
                        busy, {rvalid1, rvalid0}, ram_save, ram_addr, a);
    end
    step();
    n_cmp++;
    if ({rvalid1, rvalid0} !== eg || rdata !== ref_mem[a] || busy !== 1'b0) begin
      n_err++; $display("FAIL read_return: got rvalid=%b rdata=%h busy=%b, required rvalid=%b rdata=%h busy=0",
                        {rvalid1, rvalid0}, rdata, busy, eg, ref_mem[a]);
    end
  endtask

  task automatic test_rr_reads();
    int exp_o[4];
    int seen;
    int g;
    exp_o = '{0, 1, 0, 1};
    seen  = 0;
    for (int i = 0; i < 4; i++) begin
      gnt_q.push_back(exp_o[i]);
      rd_q.push_back('{exp_o[i], (exp_o[i] == 0) ? ref_mem[16'h0010] : ref_mem[16'h0020]});
    end
    drive(0, 1'b0, 16'h0010, 8'h00);
    drive(1, 1'b0, 16'h0020, 8'h00);
    for (int c = 0; c < 40 && seen < 4; c++) begin
      step();
      if (gnt0 || gnt1) begin
        g = gnt1 ? 1 : 0;
        n_cmp++;
        if (g !== exp_o[seen]) begin
          n_err++; $display("FAIL rr_order: grant %0d got port %0d, required port %0d", seen, g, exp_o[seen]);
        end
        seen++;
        if (seen == 4) begin
          req0 = 1'b0; req1 = 1'b0;
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_cmp++;
    if (seen !== 4) begin
      n_err++; $display("FAIL rr_timeout: got %0d grants, required 4", seen);
    end
    step(); step(); step();
  endtask

  task automatic test_reset_mid();
    int rv;
    gnt_q.push_back(0);
    rd_q.push_back('{0, ref_mem[16'h0010]});
    drive(0, 1'b0, 16'h0010, 8'h00);
    step();
    req0 = 1'b0;
    step();
    res = 1'b1;
    #1;
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1, busy, ram_save} !== 6'b0 || ram_addr !== 16'h0000 || rdata !== 8'h00) begin
      n_err++; $display("FAIL reset_async: got ctl=%b addr=%h rdata=%h, required all zero", {gnt0, gnt1, rvalid0, rvalid1, busy, ram_save}, ram_addr, rdata);
    end
    gnt_q.delete();
    rd_q.delete();
    step(); step();
    res = 1'b0;
    rv = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (rvalid0 || rvalid1) rv++;
    end
    n_cmp++;
    if (rv !== 0) begin
      n_err++; $display("FAIL reset_rvalid_discard: got %0d rvalid pulses, required 0", rv);
    end
    gnt_q.push_back(0);
    rd_q.push_back('{0, ref_mem[16'h0010]});
    drive(0, 1'b0, 16'h0010, 8'h00);
    drive(1, 1'b0, 16'h0020, 8'h00);
    step();
    n_cmp++;
    if ({gnt1, gnt0} !== 2'b01) begin
      n_err++; $display("FAIL reset_first_tie: got gnt=%b, required 01", {gnt1, gnt0});
    end
    req0 = 1'b0; req1 = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_drop();
    int g0;
    int sv;
    gnt_q.push_back(1);
    rd_q.push_back('{1, ref_mem[16'h0020]});
    drive(1, 1'b0, 16'h0020, 8'h00);
    step();
    req1 = 1'b0;
    drive(0, 1'b1, 16'h0040, 8'hEE);
    step();
    req0 = 1'b0;
    g0 = 0; sv = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (gnt0) g0++;
      if (ram_save) sv++;
    end
    n_cmp++;
    if (g0 !== 0 || sv !== 0) begin
      n_err++; $display("FAIL drop_req: got gnt0 pulses=%0d ram_save pulses=%0d, required 0 and 0", g0, sv);
    end
  endtask

`ifdef GOOFY_ARB_LOCK_EN
  task automatic test_lock();
    int exp_o[6];
    int seen;
    int g;
    exp_o = '{0, 0, 1, 0, 0, 1};
    seen  = 0;
    for (int i = 0; i < 6; i++) gnt_q.push_back(exp_o[i]);
    ref_mem[16'h0050] = 8'h11;
    ref_mem[16'h0060] = 8'h22;
    lock0 = 1'b1;
    drive(0, 1'b1, 16'h0050, 8'h11);
    drive(1, 1'b1, 16'h0060, 8'h22);
    for (int c = 0; c < 60 && seen < 6; c++) begin
      step();
      if (gnt0 || gnt1) begin
        g = gnt1 ? 1 : 0;
        n_cmp++;
        if (g !== exp_o[seen]) begin
          n_err++; $display("FAIL lock_order: grant %0d got port %0d, required port %0d", seen, g, exp_o[seen]);
        end
        seen++;
        if (seen == 6) begin
          req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
    n_cmp++;
    if (seen !== 6) begin
      n_err++; $display("FAIL lock_timeout: got %0d grants, required 6", seen);
    end
    step(); step();
  endtask
`endif

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_write(0, 16'h0010, 8'hA5);
    test_read(1, 16'h0010);
    test_write(1, 16'h0020, 8'h3C);
    test_rr_reads();
    test_reset_mid();
    test_drop();
`ifdef GOOFY_ARB_LOCK_EN
    test_lock();
`endif
    step(); step();
    n_cmp++;
    if (gnt_q.size() !== 0 || rd_q.size() !== 0) begin
      n_err++; $display("FAIL sb_drain: got %0d grants and %0d reads outstanding, required 0 and 0", gnt_q.size(), rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
